// File: rtl/demux_16.sv
// Write side of the 16-way one-hot select mux: sixteen source registers loaded
// through a valid/ready port or bulk-cleared in order, plus the registered select.
module demux_16 #(
  parameter logic [18:0] CLEAR_VAL = 19'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_valid,
  input  logic [3:0]  wr_idx,
  input  logic [18:0] wr_data,
  output logic        wr_ready,
  input  logic        clr_start,
  output logic        clr_busy,
  input  logic [15:0] sel_req,
  input  logic        sel_stb,
  output logic [15:0] c,
  output logic [18:0] out0,
  output logic [18:0] out1,
  output logic [18:0] out2,
  output logic [18:0] out3,
  output logic [18:0] out4,
  output logic [18:0] out5,
  output logic [18:0] out6,
  output logic [18:0] out7,
  output logic [18:0] out8,
  output logic [18:0] out9,
  output logic [18:0] out10,
  output logic [18:0] out11,
  output logic [18:0] out12,
  output logic [18:0] out13,
  output logic [18:0] out14,
  output logic [18:0] out15
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  clr_ptr_reg, clr_ptr_next;
  logic [18:0] entry_reg [16];
  logic [15:0] c_reg, c_next;
  logic        wr_fire, clr_fire;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      clr_ptr_reg <= 4'd0;
    end else begin
      state_reg   <= state_next;
      clr_ptr_reg <= clr_ptr_next;
    end
  end

  // Pointer wrap 15 -> 0 ends the clear; clr_start while clearing is ignored.
  always_comb begin
    state_next   = state_reg;
    clr_ptr_next = clr_ptr_reg;
    wr_ready     = 1'b0;
    clr_busy     = 1'b0;
    case (state_reg)
      IDLE: begin
        wr_ready = 1'b1;
        if (clr_start) begin
          state_next   = CLEAR;
          clr_ptr_next = 4'd0;
        end
      end
      CLEAR: begin
        clr_busy     = 1'b1;
        clr_ptr_next = clr_ptr_reg + 4'd1;
        if (clr_ptr_reg == 4'd15) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign wr_fire  = wr_valid && (state_reg == IDLE);
  assign clr_fire = (state_reg == CLEAR);

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_entry
      always_ff @(posedge clock) begin
        if (reset)
          entry_reg[gi] <= 19'd0;
        else if (clr_fire && clr_ptr_reg == 4'(gi))
          entry_reg[gi] <= CLEAR_VAL;
        else if (wr_fire && wr_idx == 4'(gi))
          entry_reg[gi] <= wr_data;
      end
    end
  endgenerate

  // Isolate the lowest set request bit; no request falls back to the background source in15.
  assign c_next = (sel_req == 16'd0) ? 16'h8000 : (sel_req & (~sel_req + 16'd1));

  always_ff @(posedge clock) begin
    if (reset)
      c_reg <= 16'h8000;
    else if (sel_stb)
      c_reg <= c_next;
  end

  assign c     = c_reg;
  assign out0  = entry_reg[0];
  assign out1  = entry_reg[1];
  assign out2  = entry_reg[2];
  assign out3  = entry_reg[3];
  assign out4  = entry_reg[4];
  assign out5  = entry_reg[5];
  assign out6  = entry_reg[6];
  assign out7  = entry_reg[7];
  assign out8  = entry_reg[8];
  assign out9  = entry_reg[9];
  assign out10 = entry_reg[10];
  assign out11 = entry_reg[11];
  assign out12 = entry_reg[12];
  assign out13 = entry_reg[13];
  assign out14 = entry_reg[14];
  assign out15 = entry_reg[15];

endmodule

// File: tb/tb_demux_16.sv
// Randomised and directed bench for demux_16, compared every cycle against a
// behavioural model of the entries, the clear sequence and the select.
module tb_demux_16;

  localparam logic [18:0] CV = 19'h00123;

  logic        clock = 1'b0;
  logic        reset, wr_valid, clr_start, sel_stb;
  logic [3:0]  wr_idx;
  logic [18:0] wr_data;
  logic [15:0] sel_req;
  logic        wr_ready, clr_busy;
  logic [15:0] c;
  logic [18:0] dut_out [16];

  int checks = 0;
  int failures = 0;
  bit do_check = 0;

  logic [18:0] m_out [16];
  logic [15:0] m_c;
  int          m_clr_left;

  always #5 clock = ~clock;

  demux_16 #(.CLEAR_VAL(CV)) dut (
    .clock(clock), .reset(reset),
    .wr_valid(wr_valid), .wr_idx(wr_idx), .wr_data(wr_data), .wr_ready(wr_ready),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .sel_req(sel_req), .sel_stb(sel_stb), .c(c),
    .out0(dut_out[0]), .out1(dut_out[1]), .out2(dut_out[2]), .out3(dut_out[3]),
    .out4(dut_out[4]), .out5(dut_out[5]), .out6(dut_out[6]), .out7(dut_out[7]),
    .out8(dut_out[8]), .out9(dut_out[9]), .out10(dut_out[10]), .out11(dut_out[11]),
    .out12(dut_out[12]), .out13(dut_out[13]), .out14(dut_out[14]), .out15(dut_out[15])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare the current state, advance the model, take the edge.
  task automatic cycle(input bit rst, input bit v, input logic [3:0] idx, input logic [18:0] d,
                       input bit start, input logic [15:0] req, input bit stb);
    bit accepted;
    reset = rst; wr_valid = v; wr_idx = idx; wr_data = d;
    clr_start = start; sel_req = req; sel_stb = stb;
    #1;
    if (do_check) begin
      check("wr_ready", 32'(wr_ready), 32'(m_clr_left == 0));
      check("clr_busy", 32'(clr_busy), 32'(m_clr_left != 0));
      check("c", 32'(c), 32'(m_c));
      check("c_onehot", 32'($onehot(c)), 32'd1);
      for (int i = 0; i < 16; i++)
        check($sformatf("out%0d", i), 32'(dut_out[i]), 32'(m_out[i]));
    end
    accepted = v && (m_clr_left == 0);
    if (rst) begin
      for (int i = 0; i < 16; i++) m_out[i] = 19'd0;
      m_c = 16'h8000;
      m_clr_left = 0;
    end else begin
      if (m_clr_left > 0) begin
        m_out[16 - m_clr_left] = CV;
        m_clr_left--;
      end else begin
        if (accepted) m_out[idx] = d;
        if (start) m_clr_left = 16;
      end
      if (stb) begin
        m_c = 16'h8000;
        for (int i = 15; i >= 0; i--)
          if (req[i]) m_c = 16'(1) << i;
      end
    end
    $display("cyc rst=%0b v=%0b idx=%0d d=%h start=%0b stb=%0b req=%h acc=%0b",
             rst, v, idx, d, start, stb, req, accepted);
    @(posedge clock);
    #1;
    if (rst) do_check = 1;
  endtask

  task automatic idle_cycle();
    cycle(0, 0, 4'd0, 19'd0, 0, 16'd0, 0);
  endtask

  initial begin
    int busy_cnt;
    for (int i = 0; i < 16; i++) m_out[i] = 19'd0;
    m_c = 16'h8000;
    m_clr_left = 0;
    @(posedge clock); #1;
    cycle(1, 0, 4'd0, 19'd0, 0, 16'd0, 0);
    cycle(1, 0, 4'd0, 19'd0, 0, 16'd0, 0);
    check("rst_c", 32'(c), 32'h8000);
    check("rst_ready", 32'(wr_ready), 32'd1);

    cycle(0, 1, 4'd3, 19'h5A5A5, 0, 16'd0, 0);
    check("w3", 32'(dut_out[3]), 32'h5A5A5);
    cycle(0, 1, 4'd15, 19'h7FFFF, 0, 16'd0, 0);
    check("w15", 32'(dut_out[15]), 32'h7FFFF);
    check("w_other", 32'(dut_out[7]), 32'd0);

    for (int i = 0; i < 16; i++) cycle(0, 1, 4'(i), 19'(i), 0, 16'd0, 0);
    cycle(0, 0, 4'd0, 19'd0, 1, 16'd0, 0);
    busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (clr_busy) busy_cnt++;
      cycle(0, 1, 4'd5, 19'h11111, 0, 16'd0, 0);
    end
    check("busy_len", 32'(busy_cnt), 32'd16);
    check("held_wr", 32'(dut_out[5]), 32'h11111);
    check("clr_out9", 32'(dut_out[9]), 32'(CV));

    cycle(0, 1, 4'd0, 19'd1, 1, 16'd0, 0);
    check("wr_clr_same", 32'(dut_out[0]), 32'd1);
    idle_cycle();
    check("wr_clr_over", 32'(dut_out[0]), 32'(CV));
    for (int k = 0; k < 16; k++) idle_cycle();

    cycle(0, 0, 4'd0, 19'd0, 0, 16'b0000_0000_0110_0000, 1);
    check("sel_0020", 32'(c), 32'h0020);
    cycle(0, 0, 4'd0, 19'd0, 0, 16'h0F00, 0);
    check("sel_hold", 32'(c), 32'h0020);
    cycle(0, 0, 4'd0, 19'd0, 0, 16'd0, 1);
    check("sel_zero", 32'(c), 32'h8000);

    cycle(0, 0, 4'd0, 19'd0, 1, 16'd0, 0);
    for (int k = 1; k < 7; k++) idle_cycle();
    cycle(1, 0, 4'd0, 19'd0, 0, 16'd0, 0);
    check("abort_ready", 32'(wr_ready), 32'd1);
    check("abort_c", 32'(c), 32'h8000);
    check("abort_out2", 32'(dut_out[2]), 32'd0);

    for (int k = 0; k < 600; k++) begin
      logic [15:0] rq;
      rq = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, 4'($urandom),
            19'($urandom), $urandom_range(0, 19) == 0, rq, $urandom_range(0, 2) == 0);
    end
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_16.md
# demux_16

Write-side companion to the 16-way 19-bit one-hot select mux in the guitarpong video path. It holds sixteen 19-bit source registers, which are the mux data inputs `in0`..`in15`. A valid/ready write port loads them individually, and a 16-cycle bulk-clear sequencer can overwrite all of them. It also generates the registered one-hot select vector `c[15:0]` that drives the mux. The mux consumes that vector unchanged.

## Interface
- `CLEAR_VAL`, 19'd0, value written to every entry by a bulk clear
- `clock`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `wr_valid`  in  1  write request
- `wr_idx`  in  4  target entry for write
- `wr_data`  in  19  write value
- `wr_ready`  out  1  write accepted this cycle when `wr_valid && wr_ready`
- `clr_start`  in  1  pulse; begin bulk clear
- `clr_busy`  out  1  high while clear in progress
- `sel_req`  in  16  per-source request lines; bit 0 highest priority
- `sel_stb`  in  1  select update strobe
- `c`  out  16  registered one-hot select to the mux
- `out0`..`out15`  out  19 each  entry registers, wired to mux `in0`..`in15`

## Operation
- FSM states:
  - IDLE: `wr_ready`=1, `clr_busy`=0. On `clr_start`, go to CLEAR with `clr_ptr`=0.
  - CLEAR: `wr_ready`=0, `clr_busy`=1. Each cycle, write `CLEAR_VAL` to entry `clr_ptr` and increment `clr_ptr`. After the write of entry 15, go to IDLE. The 4-bit pointer wrap from 15 to 0 is the terminal condition.
- Writes:
  - A write is accepted only in IDLE when `wr_valid`=1.
  - On acceptance, `out[wr_idx]` ← `wr_data` at the next edge. No other entry changes.
- `clr_start` and an accepted write in the same IDLE cycle:
  - The write is performed.
  - The clear starts on the next cycle, so a write to any index is overwritten when the clear reaches it.
- `clr_start` during CLEAR is ignored. The sequence is not restarted.
- `wr_valid` during CLEAR is not accepted. The requester holds `wr_idx`/`wr_data` until `wr_ready`.
- Select generation, when `sel_stb`=1 at an edge:
  - `c` ← one-hot of the lowest set bit of `sel_req`.
  - If `sel_req`=0, `c` ← 16'h8000, which selects `in15` as the background/default source.
- With `sel_stb`=0, `c` holds.
- `c` is always exactly one-hot and never zero. This guarantees the mux's priority tree resolves unambiguously.
- Select generation is independent of the FSM and continues during CLEAR.

## Timing
- Reset values:
  - all `out0`..`out15` = 0
  - `c` = 16'h8000
  - `wr_ready`=1, `clr_busy`=0, FSM=IDLE, `clr_ptr`=0
- Reset asserted mid-clear aborts the clear. Entries return to 0, not to `CLEAR_VAL`.
- Write latency: 1 cycle. The data is visible on `outN` the cycle after acceptance.
- Clear:
  - `clr_busy` rises the cycle after `clr_start` and stays high for exactly 16 cycles.
  - Entry k shows `CLEAR_VAL` from cycle k+2 relative to `clr_start` at cycle 0.
  - `wr_ready` returns high in the cycle after entry 15 is written.
- Select latency: 1 cycle from the `sel_stb` edge to `c`. `sel_req` is sampled only at strobe edges.
- `wr_ready` and `clr_busy` are combinational from the registered FSM state only, with no input-to-output paths.

## Test plan
- Reset, then write idx 3 = 19'h5A5A5 and idx 15 = 19'h7FFFF → `out3`=5A5A5 and `out15`=7FFFF one cycle after each; all other outputs remain 0.
- Load all 16 entries with their index, pulse `clr_start` (`CLEAR_VAL`=19'h00123), and hold `wr_valid` during the clear:
  - `clr_busy` is high for 16 cycles and `wr_ready` is low for the same 16 cycles.
  - Entries flip to 00123 in order 0..15, one per cycle.
  - The held write is accepted on the first cycle after the clear.
- `clr_start` together with `wr_valid` (idx 0, data 1) in IDLE → `out0`=1 for exactly one cycle, then 00123.
- `sel_req`=16'b0000_0000_0110_0000 with `sel_stb` → `c`=16'h0020.
  - `sel_req`=0 with strobe → `c`=16'h8000.
  - Changing `sel_req` with `sel_stb`=0 → `c` unchanged.
- Assert `reset` at clear cycle 7 → all entries 0, `c`=16'h8000, IDLE, `wr_ready`=1 on the next cycle.
- Randomised writes and strobes against a reference model → `c` is always one-hot, and every `outN` matches the model each cycle.
